// File: rtl/stream_lane_resizer.sv
// Per-lane width converter with truncate/extend/saturate modes behind a
// two-entry (output + skid) valid/ready buffer and a sticky saturation counter.
module stream_lane_resizer #(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 39,
  parameter int DATA_COUNT = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      cfg_mode,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_COUNT*IN_WIDTH-1:0]  s_data,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_COUNT*OUT_WIDTH-1:0] m_data,
  output logic                            m_last,
  output logic [DATA_COUNT-1:0]           m_sat,
  output logic [CNT_WIDTH-1:0]            sat_count,
  input  logic                            clr_count
);

  // Returns {sat, value}; shifts keep the body legal for any width pairing.
  function automatic logic [OUT_WIDTH:0] narrow_lane(input logic [IN_WIDTH-1:0] v,
                                                     input logic [1:0] mode);
    logic signed [IN_WIDTH-1:0] sv;
    logic signed [IN_WIDTH-1:0] hs;
    logic [IN_WIDTH-1:0]        hu;
    logic [OUT_WIDTH-1:0]       smin;
    sv = v;
    hs = sv >>> (OUT_WIDTH - 1);
    hu = v >> OUT_WIDTH;
    smin = '0;
    smin[OUT_WIDTH-1] = 1'b1;
    narrow_lane = {1'b0, OUT_WIDTH'(v)};
    case (mode)
      2'd2: if (hs != '0 && hs != '1) narrow_lane = {1'b1, sv[IN_WIDTH-1] ? smin : ~smin};
      2'd3: if (hu != '0) narrow_lane = {1'b1, {OUT_WIDTH{1'b1}}};
      default: ;
    endcase
  endfunction

  function automatic logic [OUT_WIDTH-1:0] widen_lane(input logic [IN_WIDTH-1:0] v,
                                                      input logic [1:0] mode);
    logic signed [IN_WIDTH-1:0] sv;
    sv = v;
    if (mode == 2'd1 || mode == 2'd2) widen_lane = OUT_WIDTH'(sv);
    else                              widen_lane = OUT_WIDTH'(v);
  endfunction

  logic [DATA_COUNT*OUT_WIDTH-1:0] conv_data_p0;
  logic [DATA_COUNT-1:0]           conv_sat_p0;
  logic                            skid_vld_p1;
  logic [DATA_COUNT*OUT_WIDTH-1:0] skid_data_p1;
  logic [DATA_COUNT-1:0]           skid_sat_p1;
  logic                            skid_last_p1;
  logic                            accept;
  logic                            take;
  logic                            load_out;
  logic                            skid_nxt;

  // Stage p0: combinational conversion of the beat on the input port
  for (genvar i = 0; i < DATA_COUNT; i++) begin : g_lane
    if (IN_WIDTH > OUT_WIDTH) begin : g_narrow
      assign {conv_sat_p0[i], conv_data_p0[i*OUT_WIDTH +: OUT_WIDTH]} =
        narrow_lane(s_data[i*IN_WIDTH +: IN_WIDTH], cfg_mode);
    end else begin : g_widen
      assign conv_data_p0[i*OUT_WIDTH +: OUT_WIDTH] =
        widen_lane(s_data[i*IN_WIDTH +: IN_WIDTH], cfg_mode);
      assign conv_sat_p0[i] = 1'b0;
    end
  end

  always_comb begin
    accept   = s_valid & s_ready;
    take     = m_valid & m_ready;
    load_out = take | ~m_valid;
    skid_nxt = load_out ? 1'b0 : (skid_vld_p1 | accept);
  end

  // Stage p1: output register with skid entry; skid drains first to keep order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      m_sat       <= '0;
      skid_vld_p1 <= 1'b0;
      s_ready     <= 1'b0;
    end else begin
      skid_vld_p1 <= skid_nxt;
      s_ready     <= ~skid_nxt;
      if (load_out) begin
        if (skid_vld_p1) begin
          m_valid <= 1'b1;
          m_data  <= skid_data_p1;
          m_sat   <= skid_sat_p1;
          m_last  <= skid_last_p1;
        end else begin
          m_valid <= accept;
          if (accept) begin
            m_data <= conv_data_p0;
            m_sat  <= conv_sat_p0;
            m_last <= s_last;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !load_out) begin
      skid_data_p1 <= conv_data_p0;
      skid_sat_p1  <= conv_sat_p0;
      skid_last_p1 <= s_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  sat_count <= '0;
    else if (clr_count)                          sat_count <= '0;
    else if (take && |m_sat && !(&sat_count))    sat_count <= sat_count + 1'b1;
  end

endmodule
